// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the unified memory port arbiter.
// The arbiter takes the slave view; requesters and the memory instance take the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              if_ack;
   logic              d_ack;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_we;
   logic              busy;
   logic [1:0]        state;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ack, d_ack, rdata, mem_addr, mem_wdata, mem_we, busy, state
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ack, d_ack, rdata, mem_addr, mem_wdata, mem_we, busy, state
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, serialising
// requests, alternating grants on contention and waiting out the memory read latency.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 2
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Counter preload: READ lasts READ_LAT cycles including the one where it hits zero.
   localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

   state_t            state_reg;
   logic [3:0]        cnt_reg;
   logic              owner_reg;   // 1 = data path, 0 = fetch
   logic              last_reg;    // last grant owner, same encoding
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              grant_data;

   // Data wins when alone, or when both request and fetch had the previous grant.
   assign grant_data = bus.d_req && (!bus.if_req || !last_reg);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         owner_reg <= 1'b0;
         last_reg  <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  owner_reg <= grant_data;
                  last_reg  <= grant_data;
                  if (grant_data) begin
                     addr_reg <= bus.d_addr;
                     if (bus.d_we) begin
                        wdata_reg <= bus.d_wdata;
                        state_reg <= WRITE;
                     end else begin
                        cnt_reg   <= CNT_INIT;
                        state_reg <= READ;
                     end
                  end else begin
                     addr_reg  <= bus.if_addr;
                     cnt_reg   <= CNT_INIT;
                     state_reg <= READ;
                  end
               end
            end
            READ: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  rdata_reg <= bus.mem_rdata;
                  state_reg <= RESP;
               end
            end
            WRITE: begin
               state_reg <= RESP;
            end
            RESP: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Decoded straight from registers so async reset clears them immediately.
   assign bus.if_ack    = (state_reg == RESP) && !owner_reg;
   assign bus.d_ack     = (state_reg == RESP) && owner_reg;
   assign bus.mem_we    = (state_reg == WRITE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.state     = state_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;
   assign bus.rdata     = rdata_reg;
endmodule
